powlib_evtlatch: RTL and testbench

//   Downstream consumer of powlib_edge: latches per-bit edge-event pulses into a

---
 rtl/powlib_evtlatch.sv | 76 +++++++
 tb/tb_powlib_evtlatch.sv | 235 +++++++++++++++++++++++
 2 files changed

// File: rtl/powlib_evtlatch.sv
// Sticky per-bit event latch with deliver-and-clear reader port, per-bit lost-event
// overflow flags and a saturating accepted-event counter.
module powlib_evtlatch #(
  parameter int           W    = 8,
  parameter logic [W-1:0] INIT = '0,
  parameter bit           EVLD = 1'b1,
  parameter int           CNTW = 16
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [W-1:0]    in_evt,
  input  logic            in_vld,
  input  logic [W-1:0]    mask,
  output logic [W-1:0]    out_dat,
  output logic            out_vld,
  input  logic            out_rdy,
  input  logic [W-1:0]    clr,
  input  logic            clr_vld,
  output logic [W-1:0]    pend,
  output logic [W-1:0]    ovf,
  output logic [CNTW-1:0] cnt,
  input  logic            cnt_clr
);

  localparam int PW = $clog2(W + 1);
  localparam int SW = ((CNTW > PW) ? CNTW : PW) + 1;
  localparam logic [SW-1:0] CNT_MAX = (SW'(1) << CNTW) - SW'(1);

  logic [W-1:0]    pend_q, pend_d;
  logic [W-1:0]    ovf_q, ovf_d;
  logic [CNTW-1:0] cnt_q, cnt_d;
  logic [W-1:0]    evt, acc, clrb;
  logic [PW-1:0]   evt_cnt;
  logic [SW-1:0]   cnt_sum;

  // Reader handshake: a word transfers in any cycle with out_vld & out_rdy; out_vld
  // and out_dat come from registers and mask only, so out_rdy never feeds back.
  assign out_dat = pend_q & mask;
  assign out_vld = |out_dat;

  assign evt  = in_evt & {W{in_vld | ~EVLD}};
  assign acc  = (out_vld & out_rdy) ? out_dat : '0;
  assign clrb = clr_vld ? clr : '0;

  always_comb begin
    evt_cnt = '0;
    for (int i = 0; i < W; i++) begin
      evt_cnt = evt_cnt + PW'(evt[i]);
    end
  end

  // A new event always wins over delivery or clear of the same bit.
  always_comb begin
    pend_d  = (pend_q & ~acc & ~clrb) | evt;
    ovf_d   = (ovf_q & ~clrb) | (evt & pend_q & ~acc & ~clrb);
    cnt_sum = (cnt_clr ? '0 : SW'(cnt_q)) + SW'(evt_cnt);
    cnt_d   = (cnt_sum > CNT_MAX) ? CNT_MAX[CNTW-1:0] : cnt_sum[CNTW-1:0];
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      pend_q <= INIT;
      ovf_q  <= '0;
      cnt_q  <= '0;
    end else begin
      pend_q <= pend_d;
      ovf_q  <= ovf_d;
      cnt_q  <= cnt_d;
    end
  end

  assign pend = pend_q;
  assign ovf  = ovf_q;
  assign cnt  = cnt_q;

endmodule

// File: tb/tb_powlib_evtlatch.sv
// Bench for powlib_evtlatch: two configurations share one input set; a per-bit
// reference model, a directed vector table and a delivered-word scoreboard.
module tb_powlib_evtlatch;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst;
  logic [7:0] in_evt, mask, clr;
  logic       in_vld, out_rdy, clr_vld, cnt_clr;

  logic [7:0]  a_dat, a_pend, a_ovf;
  logic        a_vld;
  logic [15:0] a_cnt;
  logic [7:0]  b_dat, b_pend, b_ovf;
  logic        b_vld;
  logic [3:0]  b_cnt;

  powlib_evtlatch #(.W(8), .INIT(8'h05), .EVLD(1'b1), .CNTW(16)) dut_a (
    .clk(clk), .rst(rst), .in_evt(in_evt), .in_vld(in_vld), .mask(mask),
    .out_dat(a_dat), .out_vld(a_vld), .out_rdy(out_rdy), .clr(clr),
    .clr_vld(clr_vld), .pend(a_pend), .ovf(a_ovf), .cnt(a_cnt), .cnt_clr(cnt_clr)
  );

  powlib_evtlatch #(.W(8), .INIT(8'h00), .EVLD(1'b0), .CNTW(4)) dut_b (
    .clk(clk), .rst(rst), .in_evt(in_evt), .in_vld(in_vld), .mask(mask),
    .out_dat(b_dat), .out_vld(b_vld), .out_rdy(out_rdy), .clr(clr),
    .clr_vld(clr_vld), .pend(b_pend), .ovf(b_ovf), .cnt(b_cnt), .cnt_clr(cnt_clr)
  );

  int errors = 0;
  int checks = 0;

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, got, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  // Index 0 models dut_a, index 1 models dut_b.
  bit   m_pend[2][8];
  bit   m_ovf[2][8];
  int   m_cnt[2];
  logic [7:0] p_init[2] = '{8'h05, 8'h00};
  bit   p_evld[2]       = '{1'b1, 1'b0};
  int   p_cmax[2]       = '{65535, 15};

  logic [7:0] exp_q[$];
  logic [7:0] got_q[$];

  function automatic logic [7:0] m_word(input int k, input bit is_ovf);
    logic [7:0] v;
    for (int i = 0; i < 8; i++) v[i] = is_ovf ? m_ovf[k][i] : m_pend[k][i];
    return v;
  endfunction

  task automatic model_step();
    for (int k = 0; k < 2; k++) begin
      int n;
      logic [7:0] offered;
      offered = m_word(k, 1'b0) & mask;
      if (!rst) begin
        for (int i = 0; i < 8; i++) begin
          m_pend[k][i] = p_init[k][i];
          m_ovf[k][i]  = 1'b0;
        end
        m_cnt[k] = 0;
      end else begin
        if (k == 0 && offered != 8'h00 && out_rdy) exp_q.push_back(offered);
        n = 0;
        for (int i = 0; i < 8; i++) begin
          bit ev, gone;
          ev   = in_evt[i] && (in_vld || !p_evld[k]);
          gone = (offered[i] && out_rdy) || (clr_vld && clr[i]);
          if (ev) n++;
          if (ev && m_pend[k][i] && !gone) m_ovf[k][i] = 1'b1;
          else if (clr_vld && clr[i])      m_ovf[k][i] = 1'b0;
          if (ev)        m_pend[k][i] = 1'b1;
          else if (gone) m_pend[k][i] = 1'b0;
        end
        m_cnt[k] = cnt_clr ? n : m_cnt[k] + n;
        if (m_cnt[k] > p_cmax[k]) m_cnt[k] = p_cmax[k];
      end
    end
  endtask

  task automatic check_model();
    logic [7:0] ea, eb;
    ea = m_word(0, 1'b0) & mask;
    eb = m_word(1, 1'b0) & mask;
    chk("a_pend", a_pend, m_word(0, 1'b0));
    chk("a_ovf",  a_ovf,  m_word(0, 1'b1));
    chk("a_cnt",  a_cnt,  m_cnt[0]);
    chk("a_dat",  a_dat,  ea);
    chk("a_vld",  a_vld,  |ea);
    chk("b_pend", b_pend, m_word(1, 1'b0));
    chk("b_ovf",  b_ovf,  m_word(1, 1'b1));
    chk("b_cnt",  b_cnt,  m_cnt[1]);
    chk("b_dat",  b_dat,  eb);
    chk("b_vld",  b_vld,  |eb);
  endtask

  // Monitor of words actually transferred by dut_a.
  always @(posedge clk) begin
    if (rst === 1'b1 && a_vld === 1'b1 && out_rdy === 1'b1) got_q.push_back(a_dat);
  end

  // ---------------- driver ----------------
  task automatic drive(input logic r, input logic [7:0] e, input logic v, input logic [7:0] m,
                       input logic rd, input logic [7:0] c, input logic cv, input logic cc);
    rst = r; in_evt = e; in_vld = v; mask = m; out_rdy = rd; clr = c; clr_vld = cv; cnt_clr = cc;
  endtask

  task automatic step();
    model_step();
    @(posedge clk);
    #1;
    check_model();
  endtask

  typedef struct {
    logic rst; logic [7:0] evt; logic vld; logic [7:0] mask; logic rdy;
    logic [7:0] clr; logic cv; logic cc;
    logic [7:0] e_pend; logic [7:0] e_ovf; int e_cnt; logic e_vld; logic [7:0] e_dat;
  } vec_t;

  vec_t tbl[17];

  function automatic vec_t mk(logic r, logic [7:0] e, logic v, logic [7:0] m, logic rd,
                              logic [7:0] c, logic cv, logic cc, logic [7:0] ep,
                              logic [7:0] eo, int ec, logic evl, logic [7:0] ed);
    vec_t t;
    t.rst = r; t.evt = e; t.vld = v; t.mask = m; t.rdy = rd; t.clr = c; t.cv = cv; t.cc = cc;
    t.e_pend = ep; t.e_ovf = eo; t.e_cnt = ec; t.e_vld = evl; t.e_dat = ed;
    return t;
  endfunction

  initial begin
    drive(1'b0, 8'h00, 1'b0, 8'hFF, 1'b0, 8'h00, 1'b0, 1'b0);

    //            rst evt    vld mask   rdy clr    cv cc   pend   ovf    cnt vld dat
    tbl[0]  = mk(0, 8'h00, 0, 8'hFF, 0, 8'h00, 0, 0,  8'h05, 8'h00, 0,  1, 8'h05);
    tbl[1]  = mk(1, 8'h00, 0, 8'hFF, 1, 8'h00, 0, 0,  8'h00, 8'h00, 0,  0, 8'h00);
    tbl[2]  = mk(1, 8'h81, 1, 8'hFF, 0, 8'h00, 0, 0,  8'h81, 8'h00, 2,  1, 8'h81);
    tbl[3]  = mk(1, 8'h00, 0, 8'hFF, 1, 8'h00, 0, 0,  8'h00, 8'h00, 2,  0, 8'h00);
    tbl[4]  = mk(1, 8'h08, 1, 8'hFF, 0, 8'h00, 0, 0,  8'h08, 8'h00, 3,  1, 8'h08);
    tbl[5]  = mk(1, 8'h08, 1, 8'hFF, 0, 8'h00, 0, 0,  8'h08, 8'h08, 4,  1, 8'h08);
    tbl[6]  = mk(1, 8'h00, 0, 8'hFF, 0, 8'h08, 1, 0,  8'h00, 8'h00, 4,  0, 8'h00);
    tbl[7]  = mk(1, 8'h04, 1, 8'hFF, 0, 8'h00, 0, 0,  8'h04, 8'h00, 5,  1, 8'h04);
    tbl[8]  = mk(1, 8'h04, 1, 8'hFF, 1, 8'h00, 0, 0,  8'h04, 8'h00, 6,  1, 8'h04);
    tbl[9]  = mk(1, 8'h00, 0, 8'hFF, 1, 8'h00, 0, 0,  8'h00, 8'h00, 6,  0, 8'h00);
    tbl[10] = mk(1, 8'h0F, 1, 8'hF0, 0, 8'h00, 0, 0,  8'h0F, 8'h00, 10, 0, 8'h00);
    tbl[11] = mk(1, 8'h00, 0, 8'hFF, 0, 8'h00, 0, 0,  8'h0F, 8'h00, 10, 1, 8'h0F);
    tbl[12] = mk(1, 8'h30, 0, 8'hFF, 0, 8'h00, 0, 0,  8'h0F, 8'h00, 10, 1, 8'h0F);
    tbl[13] = mk(1, 8'h10, 1, 8'hFF, 0, 8'h00, 0, 1,  8'h1F, 8'h00, 1,  1, 8'h1F);
    tbl[14] = mk(1, 8'h01, 1, 8'hFF, 0, 8'h01, 0, 0,  8'h1F, 8'h01, 2,  1, 8'h1F);
    tbl[15] = mk(1, 8'h01, 1, 8'hFF, 0, 8'h01, 1, 0,  8'h1F, 8'h00, 3,  1, 8'h1F);
    tbl[16] = mk(0, 8'hFF, 1, 8'hFF, 1, 8'h00, 0, 0,  8'h05, 8'h00, 0,  1, 8'h05);

    for (int i = 0; i < 17; i++) begin
      drive(tbl[i].rst, tbl[i].evt, tbl[i].vld, tbl[i].mask, tbl[i].rdy, tbl[i].clr,
            tbl[i].cv, tbl[i].cc);
      step();
      chk($sformatf("tbl%0d_pend", i), a_pend, tbl[i].e_pend);
      chk($sformatf("tbl%0d_ovf", i),  a_ovf,  tbl[i].e_ovf);
      chk($sformatf("tbl%0d_cnt", i),  a_cnt,  tbl[i].e_cnt);
      chk($sformatf("tbl%0d_vld", i),  a_vld,  tbl[i].e_vld);
      chk($sformatf("tbl%0d_dat", i),  a_dat,  tbl[i].e_dat);
    end

    // Counter saturation and clear-then-count on the narrow, unqualified instance.
    drive(1'b0, 8'h00, 1'b0, 8'hFF, 1'b0, 8'h00, 1'b0, 1'b0);
    step();
    drive(1'b1, 8'hFF, 1'b0, 8'hFF, 1'b0, 8'h00, 1'b0, 1'b0);
    step();
    chk("sat_cnt1", b_cnt, 4'd8);
    chk("sat_pend1", b_pend, 8'hFF);
    chk("sat_a_ignored", a_pend, 8'h05);
    step();
    chk("sat_cnt2", b_cnt, 4'd15);
    chk("sat_ovf2", b_ovf, 8'hFF);
    step();
    chk("sat_cnt3", b_cnt, 4'd15);
    drive(1'b1, 8'h03, 1'b0, 8'hFF, 1'b0, 8'h00, 1'b0, 1'b1);
    step();
    chk("clr_cnt", b_cnt, 4'd2);

    // Mask hides a pending bit, unmasking exposes it in the same cycle.
    drive(1'b1, 8'h00, 1'b0, 8'h00, 1'b1, 8'hFF, 1'b1, 1'b0);
    step();
    drive(1'b1, 8'h40, 1'b1, 8'hBF, 1'b1, 8'h00, 1'b0, 1'b0);
    step();
    chk("mask_hold_vld", a_vld, 1'b0);
    step();
    chk("mask_hold_pend", a_pend, 8'h40);
    mask = 8'hFF;
    #1;
    chk("unmask_dat", a_dat, 8'h40);
    chk("unmask_vld", a_vld, 1'b1);

    // Randomized traffic against the model.
    for (int n = 0; n < 400; n++) begin
      drive(($urandom_range(0, 60) != 0),
            8'($urandom_range(0, 255) & $urandom_range(0, 255)),
            ($urandom_range(0, 3) != 0),
            ($urandom_range(0, 3) == 0) ? 8'($urandom_range(0, 255)) : 8'hFF,
            ($urandom_range(0, 2) == 0),
            8'($urandom_range(0, 255)),
            ($urandom_range(0, 5) == 0),
            ($urandom_range(0, 15) == 0));
      step();
    end

    drive(1'b1, 8'h00, 1'b0, 8'hFF, 1'b0, 8'h00, 1'b0, 1'b0);
    @(posedge clk);
    #1;

    // ---------------- scoreboard ----------------
    chk("sb_count", got_q.size(), exp_q.size());
    while (exp_q.size() > 0 && got_q.size() > 0) begin
      logic [7:0] e, g;
      e = exp_q.pop_front();
      g = got_q.pop_front();
      chk("sb_word", g, e);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
